// File: rtl/rcc_pkg.sv
// rcc_pkg: shared state encoding, level constants and div_sel <-> level
// conversion helpers for the RCC divider sequencer.
package rcc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ACK    = 2'd3
    } seq_state_t;

    localparam logic [2:0] LVL_DIV1  = 3'd0;
    localparam logic [2:0] LVL_DIV2  = 3'd1;
    localparam logic [2:0] LVL_DIV4  = 3'd2;
    localparam logic [2:0] LVL_DIV8  = 3'd3;
    localparam logic [2:0] LVL_DIV16 = 3'd4;

    // 0xx -> /1, 1ab -> level ab+1
    function automatic logic [2:0] sel2lvl(input logic [2:0] sel);
        logic [2:0] lvl;
        if (!sel[2]) begin
            lvl = LVL_DIV1;
        end else begin
            lvl = {1'b0, sel[1:0]} + 3'd1;
        end
        return lvl;
    endfunction

    // level 0 -> 000, level n -> {1, n-1}; level 4 wraps its low bits to 11
    function automatic logic [2:0] lvl2sel(input logic [2:0] lvl);
        logic [2:0] sel;
        if (lvl == LVL_DIV1) begin
            sel = 3'b000;
        end else begin
            sel = {1'b1, lvl[1:0] - 2'd1};
        end
        return sel;
    endfunction

endpackage

// File: rtl/rcc_rr_arb.sv
// rcc_rr_arb: combinational round-robin arbiter. Grants the first active
// requester at or after ptr_i, wrapping; reusable by other RCC muxes.
module rcc_rr_arb #(
    parameter int NREQ = 3,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            gnt_vld_o
);

    // Two passes: requesters at/after the pointer first, then the wrapped ones.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (en_i && !gnt_vld_o && req_i[i] && (IW'(i) >= ptr_i)) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'(i);
                gnt_o[i]  = 1'b1;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (en_i && !gnt_vld_o && req_i[i] && (IW'(i) < ptr_i)) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'(i);
                gnt_o[i]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rcc_div_seq.sv
// rcc_div_seq: arbitrates ratio-change requests and walks div_sel toward the
// granted target, holding a settle window after every change.
// Build option RCC_DIV_SEQ_STEP_EN: when defined, each STEP moves one ratio
// level toward the target; otherwise STEP jumps straight to the target.
//
// state   | meaning
// IDLE    | waiting for a request; arbitrates and latches target
// STEP    | apply next level; div_sel/cur_lvl visible next cycle
// SETTLE  | hold SETTLE_CYC cycles after a div_sel change
// ACK     | one-cycle req_ack pulse to the granted requester
module rcc_div_seq
    import rcc_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int SETTLE_CYC = 16,
    parameter int RST_LVL    = 0
) (
    input  logic              i_clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_vld,
    input  logic [3*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]   req_ack,
    output logic [2:0]        div_sel,
    output logic [2:0]        cur_lvl,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    seq_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_oh_q, gnt_oh_d;
    logic [2:0]      tgt_lvl_q, tgt_lvl_d;
    logic [2:0]      lvl_q, lvl_d;
    logic [2:0]      sel_q;
    logic [7:0]      cnt_q, cnt_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_vld;
    logic [2:0]      sel_g;
    logic [2:0]      lvl_step;

    rcc_rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_i     (req_vld),
        .ptr_i     (ptr_q),
        .en_i      (state_q == ST_IDLE),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    // Target selector of the requester currently winning arbitration.
    always_comb begin
        sel_g = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_g = req_sel[3*i +: 3];
            end
        end
    end

    // Level applied by one STEP.
    always_comb begin
`ifdef RCC_DIV_SEQ_STEP_EN
        lvl_step = (tgt_lvl_q > lvl_q) ? lvl_q + 3'd1 : lvl_q - 3'd1;
`else
        lvl_step = tgt_lvl_q;
`endif
    end

    // Next-state logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_oh_d  = gnt_oh_q;
        tgt_lvl_d = tgt_lvl_q;
        lvl_d     = lvl_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    gnt_oh_d  = arb_gnt;
                    tgt_lvl_d = sel2lvl(sel_g);
                    ptr_d     = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                    state_d   = (sel2lvl(sel_g) == lvl_q) ? ST_ACK : ST_STEP;
                end
            end
            ST_STEP: begin
                lvl_d   = lvl_step;
                cnt_d   = 8'(SETTLE_CYC - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = (lvl_q == tgt_lvl_q) ? ST_ACK : ST_STEP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; div_sel is re-encoded from the next level.
    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            gnt_oh_q  <= '0;
            tgt_lvl_q <= 3'(RST_LVL);
            lvl_q     <= 3'(RST_LVL);
            sel_q     <= lvl2sel(3'(RST_LVL));
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_oh_q  <= gnt_oh_d;
            tgt_lvl_q <= tgt_lvl_d;
            lvl_q     <= lvl_d;
            sel_q     <= lvl2sel(lvl_d);
            cnt_q     <= cnt_d;
        end
    end

    assign req_ack = (state_q == ST_ACK) ? gnt_oh_q : '0;
    assign busy    = (state_q != ST_IDLE);
    assign cur_lvl = lvl_q;
    assign div_sel = sel_q;

endmodule

// File: tb/tb_rcc_div_seq.sv
// tb_rcc_div_seq: directed scenarios plus randomized traffic, compared every
// cycle against a transaction-level model of grant order and step timing.
module tb_rcc_div_seq;

    localparam int NREQ = 3;
    localparam int S    = 16;
    localparam int RSTL = 0;
`ifdef RCC_DIV_SEQ_STEP_EN
    localparam bit STEPW = 1'b1;
`else
    localparam bit STEPW = 1'b0;
`endif

    logic              i_clk   = 1'b0;
    logic              rst     = 1'b1;
    logic [NREQ-1:0]   req_vld = '0;
    logic [3*NREQ-1:0] req_sel = '0;
    logic [NREQ-1:0]   req_ack;
    logic [2:0]        div_sel;
    logic [2:0]        cur_lvl;
    logic              busy;

    rcc_div_seq #(.NREQ(NREQ), .SETTLE_CYC(S), .RST_LVL(RSTL)) dut (
        .i_clk   (i_clk),
        .rst     (rst),
        .req_vld (req_vld),
        .req_sel (req_sel),
        .req_ack (req_ack),
        .div_sel (div_sel),
        .cur_lvl (cur_lvl),
        .busy    (busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit armed  = 1'b0;

    // reference model state: one in-flight transaction at most
    bit m_act = 1'b0;
    int m_t, m_a, m_k, m_l0, m_tg, m_g;
    int m_lvl = RSTL;
    int m_ptr = 0;

    int         dsel_chg[$];
    int         busy_cnt  = 0;
    int         ack_total = 0;
    logic [2:0] last_dsel;
    bit         have_dsel = 1'b0;

    function automatic int lvl_of_sel(input logic [2:0] s);
        case (s)
            3'b100:  return 1;
            3'b101:  return 2;
            3'b110:  return 3;
            3'b111:  return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] sel_of_lvl(input int l);
        case (l)
            1:       return 3'b100;
            2:       return 3'b101;
            3:       return 3'b110;
            4:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    // level expected in cycle c: one change every S+1 cycles starting at t+2
    function automatic int exp_lvl(input int c);
        int n;
        if (!m_act) return m_lvl;
        if (c < m_t + 2) n = 0;
        else n = (c - m_t - 2) / (S + 1) + 1;
        if (n > m_k) n = m_k;
        if (STEPW) return (m_tg > m_l0) ? m_l0 + n : m_l0 - n;
        return (n > 0) ? m_tg : m_l0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model update at each edge using the inputs presented in the ending cycle.
    always @(posedge i_clk) begin
        int d;
        if (rst) begin
            m_act = 1'b0;
            m_lvl = RSTL;
            m_ptr = 0;
            armed = 1'b1;
        end else if (m_act) begin
            if (cyc == m_a) begin
                m_act = 1'b0;
                m_lvl = m_tg;
            end
        end else if (req_vld != '0) begin
            m_g   = pick(req_vld, m_ptr);
            m_ptr = (m_g + 1) % NREQ;
            m_l0  = m_lvl;
            m_tg  = lvl_of_sel(req_sel[3*m_g +: 3]);
            d     = (m_tg > m_l0) ? m_tg - m_l0 : m_l0 - m_tg;
            m_k   = (d == 0) ? 0 : (STEPW ? d : 1);
            m_t   = cyc;
            m_a   = m_t + 1 + m_k * (S + 1);
            m_act = 1'b1;
        end
        cyc++;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge i_clk) begin
        logic [31:0] ea;
        int          el;
        if (armed) begin
            ea = (m_act && cyc == m_a) ? (32'd1 << m_g) : 32'd0;
            el = exp_lvl(cyc);
            chk("req_ack", 32'(req_ack), ea);
            chk("busy", 32'(busy), 32'(m_act));
            chk("cur_lvl", 32'(cur_lvl), el);
            chk("div_sel", 32'(div_sel), 32'(sel_of_lvl(el)));
            if (busy) busy_cnt++;
            if (req_ack != '0) ack_total++;
            if (have_dsel && div_sel != last_dsel) dsel_chg.push_back(cyc);
            last_dsel = div_sel;
            have_dsel = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ack(input int idx, input int budget, output int at);
        at = -1;
        for (int b = 0; b < budget; b++) begin
            step(1);
            if (req_ack[idx]) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL ack_timeout req%0d: got none expected ack within %0d cycles", idx, budget);
        end
    endtask

    task automatic wait_any(input int budget, output int idx);
        idx = -1;
        for (int b = 0; b < budget; b++) begin
            step(1);
            if (req_ack != '0) begin
                for (int i = NREQ - 1; i >= 0; i--) if (req_ack[i]) idx = i;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL any_ack_timeout: got none expected ack within %0d cycles", budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int t0, at, idx, n0;
        int order[$];

        // reset values
        rst = 1'b1;
        step(3);
        chk("rst_div_sel", 32'(div_sel), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ack", 32'(req_ack), 32'h0);
        chk("rst_lvl", 32'(cur_lvl), 32'h0);
        rst = 1'b0;
        step(1);

        // /1 -> /4
        dsel_chg.delete();
        t0 = cyc;
        req_sel[2:0] = 3'b101;
        req_vld = 3'b001;
        wait_ack(0, 200, at);
        req_vld = '0;
        chk("s1_ack_lat", at - t0, STEPW ? 35 : 18);
        chk("s1_nchg", dsel_chg.size(), STEPW ? 2 : 1);
        chk("s1_chg0", (dsel_chg.size() > 0) ? dsel_chg[0] - t0 : -1, 2);
`ifdef RCC_DIV_SEQ_STEP_EN
        chk("s1_chg1", (dsel_chg.size() > 1) ? dsel_chg[1] - t0 : -1, 19);
`endif
        chk("s1_div_sel", 32'(div_sel), 32'b101);

        // back to /1 via req2 so the pointer sits at 0
        req_sel = '0;
        req_vld = 3'b100;
        wait_ack(2, 200, at);
        req_vld = '0;

        // three simultaneous requesters, held for two rounds
        req_sel = {3'b000, 3'b100, 3'b111};
        req_vld = 3'b111;
        for (int r = 0; r < 6; r++) begin
            wait_any(300, idx);
            order.push_back(idx);
        end
        req_vld = '0;
        for (int r = 0; r < 6; r++) chk("rr_order", order[r], r % 3);

        // same-level request
        step(1);
        dsel_chg.delete();
        busy_cnt = 0;
        t0 = cyc;
        req_sel[5:3] = 3'b000;
        req_vld = 3'b010;
        wait_ack(1, 50, at);
        req_vld = '0;
        step(2);
        chk("s4_ack_lat", at - t0, 1);
        chk("s4_nchg", dsel_chg.size(), 0);
        chk("s4_busy_cyc", busy_cnt, 1);

        // drop req_vld and change req_sel mid-transaction
        t0 = cyc;
        req_sel[2:0] = 3'b111;
        req_vld = 3'b001;
        step(8);
        req_vld = '0;
        req_sel[2:0] = 3'b100;
        wait_ack(0, 200, at);
        chk("s5_lvl", 32'(cur_lvl), 32'd4);
        chk("s5_ack_lat", at - t0, STEPW ? 69 : 18);

        // back to /1, then reset in the middle of a /1 -> /16 walk
        req_sel[8:6] = 3'b000;
        req_vld = 3'b100;
        wait_ack(2, 200, at);
        req_vld = '0;
        step(1);
        n0 = ack_total;
        req_sel[2:0] = 3'b111;
        req_vld = 3'b001;
        step(STEPW ? 25 : 8);
        rst = 1'b1;
        req_vld = '0;
        step(1);
        rst = 1'b0;
        chk("s6_div_sel", 32'(div_sel), 32'h0);
        chk("s6_busy", 32'(busy), 32'h0);
        chk("s6_lvl", 32'(cur_lvl), 32'h0);
        step(80);
        chk("s6_no_ack", ack_total - n0, 0);
        t0 = cyc;
        req_sel[5:3] = 3'b110;
        req_vld = 3'b010;
        wait_ack(1, 200, at);
        req_vld = '0;
        chk("s6_fresh_lat", at - t0, STEPW ? 52 : 18);
        chk("s6_fresh_sel", 32'(div_sel), 32'b110);

        // randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i] && $urandom_range(3) != 0) begin
                    req_vld[i] = 1'b0;
                end else if (!req_vld[i] && $urandom_range(7) == 0) begin
                    req_vld[i] = 1'b1;
                    req_sel[3*i +: 3] = 3'($urandom_range(7));
                end else if ($urandom_range(15) == 0) begin
                    req_sel[3*i +: 3] = 3'($urandom_range(7));
                end
            end
            rst = ($urandom_range(499) == 0);
            step(1);
        end
        rst = 1'b0;
        req_vld = '0;
        step(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
